// File: rtl/fir_fixed_acc_round_sat_pkg.sv
// rtl/fir_fixed_acc_round_sat_pkg.sv - shared widths, sample types and saturation limits for the FIR accumulator
package fir_fixed_acc_pkg;

    localparam int PROD_W = 43;
    localparam int ACC_W  = 48;
    localparam int OUT_W  = 24;
    localparam int SHIFT  = 17;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0]  sample_t;
    // One guard bit above the accumulator so the rounding add cannot wrap.
    typedef logic signed [ACC_W:0]    wide_t;

    // Largest (upper=1) or smallest (upper=0) value representable in OUT_W bits,
    // expressed at the widened rounding precision.
    function automatic wide_t sat_limit(input logic upper);
        wide_t one;
        one = {{ACC_W{1'b0}}, 1'b1};
        if (upper) begin
            return (one <<< (OUT_W - 1)) - one;
        end
        return -(one <<< (OUT_W - 1));
    endfunction

endpackage

// File: rtl/fir_fixed_acc_round_sat_if.sv
// rtl/fir_fixed_acc_round_sat_if.sv - product input and sample output handshake bundle
interface fir_fixed_acc_round_sat_if;
    import fir_fixed_acc_pkg::*;

    logic    in_valid;
    logic    in_ready;
    prod_t   prod_data;
    logic    out_valid;
    logic    out_ready;
    sample_t out_data;

    // Upstream multiplier plus downstream sample consumer.
    modport master (
        output in_valid,
        output prod_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The accumulator block.
    modport slave (
        input  in_valid,
        input  prod_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/fir_fixed_round_sat.sv
// rtl/fir_fixed_round_sat.sv - combinational half-up rounding and saturation of a wide sum to an output sample
module fir_fixed_round_sat
    import fir_fixed_acc_pkg::*;
(
    input  acc_t    sum,
    output sample_t out_data,
    output logic    sat
);

    localparam wide_t HALF   = wide_t'(1) <<< (SHIFT - 1);
    localparam wide_t SAT_HI = sat_limit(1'b1);
    localparam wide_t SAT_LO = sat_limit(1'b0);

    wide_t ext;
    wide_t rnd;

    // Round half toward +inf at one extra bit, then clamp into the sample range.
    always_comb begin
        ext      = $signed({sum[ACC_W-1], sum}) + HALF;
        rnd      = ext >>> SHIFT;
        out_data = rnd[OUT_W-1:0];
        sat      = 1'b0;
        if (rnd > SAT_HI) begin
            out_data = SAT_HI[OUT_W-1:0];
            sat      = 1'b1;
        end else if (rnd < SAT_LO) begin
            out_data = SAT_LO[OUT_W-1:0];
            sat      = 1'b1;
        end
    end

endmodule

// File: rtl/fir_fixed_acc_round_sat.sv
// rtl/fir_fixed_acc_round_sat.sv - NUM_TAPS product accumulator with rounded, saturated sample output (optional FIR_FIXED_ACC_SAT_FLAG_EN sticky sat flag)
module fir_fixed_acc_round_sat
    import fir_fixed_acc_pkg::*;
#(
    parameter int NUM_TAPS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
    input  logic sat_clr,
    output logic sat_flag,
`endif
    fir_fixed_acc_round_sat_if.slave bus
);

    localparam int TC_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    generate
        if (NUM_TAPS < 1 || NUM_TAPS > 256) begin : g_bad_taps
            $error("NUM_TAPS must be in 1..256");
        end
        if (ACC_W < PROD_W + TC_W + 1) begin : g_bad_acc
            $error("ACC_W too narrow for NUM_TAPS products");
        end
    endgenerate

    acc_t            acc, acc_d;
    logic [TC_W-1:0] tap_cnt, tap_d;
    logic            out_valid_q, out_valid_d;
    sample_t         out_data_q, out_data_d;

    logic    accept;
    logic    take;
    logic    last_tap;
    acc_t    prod_ext;
    acc_t    sum;
    sample_t rs_data;
    logic    rs_sat;

    // A new product may enter unless a finished sample is stuck waiting.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign accept   = ce && bus.in_valid && bus.in_ready;
    assign take     = ce && out_valid_q && bus.out_ready;
    assign last_tap = (tap_cnt == TC_W'(NUM_TAPS - 1));
    assign prod_ext = {{(ACC_W - PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
    assign sum      = acc + prod_ext;

    fir_fixed_round_sat u_round_sat (
        .sum      (sum),
        .out_data (rs_data),
        .sat      (rs_sat)
    );

    // Next-state: accumulate on each accepted tap, emit and restart on the last one.
    always_comb begin
        acc_d       = acc;
        tap_d       = tap_cnt;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (take) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (last_tap) begin
                acc_d       = '0;
                tap_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = rs_data;
            end else begin
                acc_d = sum;
                tap_d = tap_cnt + TC_W'(1);
            end
        end
    end

    // State registers; everything freezes while ce is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            tap_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (ce) begin
            acc         <= acc_d;
            tap_cnt     <= tap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
    // Sticky saturation indicator; a new saturating sample beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (ce) begin
            if (accept && last_tap && rs_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end
`else
    logic unused_rs_sat;
    assign unused_rs_sat = rs_sat;
`endif

endmodule

// File: tb/tb_fir_fixed_acc_round_sat.sv
// tb/tb_fir_fixed_acc_round_sat.sv - scoreboard bench for the FIR accumulator with round and saturate
module tb_fir_fixed_acc_round_sat;
    import fir_fixed_acc_pkg::*;

    localparam int TAPS = 16;

    logic clk;
    logic reset;
    logic ce;
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
    logic sat_clr;
    logic sat_flag;
`endif

    fir_fixed_acc_round_sat_if bus ();

    fir_fixed_acc_round_sat #(.NUM_TAPS(TAPS)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    prod_t  frame[$];
    longint exp_q[$];
    bit     ce_tog = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: an output sample is the rounded, clamped sum of every 16 accepted products.
    function automatic void model_push(input prod_t d);
        longint s;
        longint r;
        frame.push_back(d);
        if (frame.size() == TAPS) begin
            s = 0;
            foreach (frame[i]) s += longint'(frame[i]);
            r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
            if (r > 8388607) r = 8388607;
            else if (r < -8388608) r = -8388608;
            exp_q.push_back(r);
            frame.delete();
        end
    endfunction

    task automatic drive(input bit v, input prod_t d, input bit c, input bit r, output bit acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.prod_data = d;
        ce            = c;
        bus.out_ready = r;
        #1;
        acc = c && v && bus.in_ready;
        if (acc) model_push(d);
    endtask

    task automatic idle(input int n, input bit r);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, r, a);
    endtask

    // mode 0: ce=1 ready=1; 1: ce toggles; 2: random ce/ready; 3: ready=0; 4: random ready
    task automatic send(input prod_t d, input int mode);
        bit a;
        bit c;
        bit r;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 200) begin
            case (mode)
                0: begin c = 1'b1; r = 1'b1; end
                1: begin c = ce_tog; ce_tog = !ce_tog; r = 1'b1; end
                2: begin c = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 9) < 7); end
                3: begin c = 1'b1; r = 1'b0; end
                default: begin c = 1'b1; r = 1'($urandom_range(0, 1)); end
            endcase
            drive(1'b1, d, c, r, a);
            n++;
        end
        if (!a) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=%0d expected acceptance within 200 cycles", bus.in_ready);
        end
    endtask

    task automatic send_pattern(input prod_t a, input int na, input prod_t b, input int mode);
        for (int i = 0; i < TAPS; i++) send((i < na) ? a : b, mode);
    endtask

    // Monitor: every sample the DUT hands over must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && ce && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_sample: got %0d expected no sample", bus.out_data);
                end else begin
                    check("sample", longint'(bus.out_data), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit a;
        prod_t p;

        reset         = 1'b1;
        ce            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod_data = '0;
        bus.out_ready = 1'b0;
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
        sat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
        check("rst_sat_flag", sat_flag, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Basic frame: 16 x 2^17 -> 16, one-cycle valid, in_ready never drops.
        ok = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            send(prod_t'(131072), 0);
            if (bus.in_ready !== 1'b1) ok = 1'b0;
        end
        check("in_ready_run", ok, 1);
        drive(1'b0, '0, 1'b1, 1'b1, a);
        check("ov_rise", bus.out_valid, 1);
        drive(1'b0, '0, 1'b1, 1'b1, a);
        check("ov_one_cycle", bus.out_valid, 0);
        check("basic_drained", exp_q.size(), 0);

        // Rounding boundaries.
        send_pattern(prod_t'(65536), 3, '0, 0);
        send_pattern(-prod_t'(65536), 3, '0, 0);
        send_pattern(-prod_t'(65536), 1, '0, 0);
        send_pattern(prod_t'(65535), 1, '0, 0);
        send_pattern(-prod_t'(65537), 1, '0, 0);

        // Saturation both ways.
        p = prod_t'(1) <<< 40;
        send_pattern(p, TAPS, '0, 0);
        send_pattern(-p, TAPS, '0, 0);
        idle(2, 1'b1);
`ifdef FIR_FIXED_ACC_SAT_FLAG_EN
        check("sat_flag_set", sat_flag, 1);
        sat_clr = 1'b1;
        idle(1, 1'b1);
        sat_clr = 1'b0;
        idle(1, 1'b1);
        check("sat_flag_clr", sat_flag, 0);
`endif
        idle(2, 1'b1);

        // Backpressure: sample held while downstream stalls, then two in order.
        send_pattern(prod_t'(131072), TAPS, '0, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, prod_t'(262144), 1'b1, 1'b0, a);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_held", longint'(bus.out_data), exp_q[0]);
        end
        send_pattern(prod_t'(262144), TAPS, '0, 4);
        idle(4, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Clock enable toggling mid-frame; completed sample holds while ce=0.
        send_pattern(prod_t'(98304), TAPS, '0, 1);
        drive(1'b0, '0, 1'b0, 1'b1, a);
        check("ce_hold_ov1", bus.out_valid, 1);
        drive(1'b0, '0, 1'b0, 1'b1, a);
        check("ce_hold_ov2", bus.out_valid, 1);
        idle(3, 1'b1);
        check("ce_drained", exp_q.size(), 0);

        // Reset after tap 7 discards the partial sum.
        for (int i = 0; i < 7; i++) send(prod_t'(5 * 131072), 0);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_ov", bus.out_valid, 0);
        frame.delete();
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;

        // Reset with a sample pending drops it asynchronously.
        send_pattern(prod_t'(3 * 131072), TAPS, '0, 3);
        drive(1'b0, '0, 1'b1, 1'b0, a);
        check("pend_ov", bus.out_valid, 1);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_pend_ov", bus.out_valid, 0);
        check("rst_pend_data", bus.out_data, 0);
        exp_q.delete();
        frame.delete();
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        send_pattern(prod_t'(131072), TAPS, '0, 0);
        idle(3, 1'b1);
        check("post_rst_drained", exp_q.size(), 0);

        // Randomized frames with random ce and downstream stalls.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < TAPS; i++) begin
                p = prod_t'({$urandom, $urandom});
                p = p >>> $urandom_range(0, 30);
                send(p, 2);
            end
        end
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1, 1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
